// File: rtl/sprite_pkg.sv
// Shared sprite-pipeline definitions: ID/colour types, geometry constants and the
// resolver FSM state encoding.
package sprite_pkg;
  localparam int unsigned ID_W       = 6;
  localparam int unsigned COORD_W    = 10;
  localparam int unsigned OFF_W      = 4;
  localparam int unsigned ADDR_W     = ID_W + 2 * OFF_W;
  localparam int unsigned SPRITE_DIM = 16;

  typedef logic [5:0] sprite_id_t;
  typedef logic [8:0] color_t;

  localparam sprite_id_t NO_SPRITE_ID = 6'h3F;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    MEM_REQ,
    CHECK,
    DONE
  } resolver_state_t;
endpackage

// File: rtl/sprite_offset_calc.sv
// Pixel offset of (H,V) inside a sprite anchored at (x,y); in_box when both
// offsets fall within the sprite tile.
module sprite_offset_calc
  import sprite_pkg::*;
(
  input  logic [COORD_W-1:0] i_h_pos,
  input  logic [COORD_W-1:0] i_v_pos,
  input  logic [COORD_W-1:0] i_anchor_x,
  input  logic [COORD_W-1:0] i_anchor_y,
  output logic [OFF_W-1:0]   o_dx_c,
  output logic [OFF_W-1:0]   o_dy_c,
  output logic               o_in_box_c
);
  // Zero-extended subtraction: the top bit is the sign of the offset
  logic [COORD_W:0] w_dx;
  logic [COORD_W:0] w_dy;

  assign w_dx = {1'b0, i_h_pos} - {1'b0, i_anchor_x};
  assign w_dy = {1'b0, i_v_pos} - {1'b0, i_anchor_y};

  assign o_dx_c     = w_dx[OFF_W-1:0];
  assign o_dy_c     = w_dy[OFF_W-1:0];
  assign o_in_box_c = !w_dx[COORD_W] && (w_dx[COORD_W-1:0] < COORD_W'(SPRITE_DIM)) &&
                      !w_dy[COORD_W] && (w_dy[COORD_W-1:0] < COORD_W'(SPRITE_DIM));
endmodule

// File: rtl/sprite_pixel_resolver.sv
// Walks the priority-ordered sprite candidates of one pixel, fetching each texel
// from sprite ROM, and returns the first opaque colour or the background colour.
module sprite_pixel_resolver
  import sprite_pkg::*;
#(
  parameter int unsigned          N_SLOTS     = 4,
  parameter int unsigned          COLOR_W     = 9,
  parameter logic [COLOR_W-1:0]   TRANSPARENT = 9'h1FF,
  parameter logic [COLOR_W-1:0]   BG_COLOR    = 9'h000
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              candidates_valid,
  input  logic [N_SLOTS-1:0][ID_W-1:0]      candidate_id,
  input  logic [COORD_W-1:0]                H_pos_in,
  input  logic [COORD_W-1:0]                V_pos_in,
  output logic                              busy,
  output logic [ID_W-1:0]                   attr_id,
  input  logic [COORD_W-1:0]                attr_x,
  input  logic [COORD_W-1:0]                attr_y,
  output logic                              mem_rd_en,
  output logic [ADDR_W-1:0]                 mem_addr,
  input  logic [COLOR_W-1:0]                mem_data,
  output logic                              pixel_valid,
  output logic                              pixel_hit,
  output logic [COLOR_W-1:0]                pixel_color
);
  localparam logic [1:0] LAST_SLOT = 2'(N_SLOTS - 1);

  resolver_state_t                  r_state, w_state_nxt;
  logic [1:0]                       r_k, w_k_nxt;
  logic [N_SLOTS-1:0][ID_W-1:0]     r_ids, w_ids_nxt;
  logic [COORD_W-1:0]               r_h, w_h_nxt;
  logic [COORD_W-1:0]               r_v, w_v_nxt;
  sprite_id_t                       r_attr_id, w_attr_id_nxt;
  logic                             r_mem_rd_en, w_mem_rd_en_nxt;
  logic [ADDR_W-1:0]                r_mem_addr, w_mem_addr_nxt;
  logic                             r_pixel_valid, w_pixel_valid_nxt;
  logic                             r_pixel_hit, w_pixel_hit_nxt;
  logic [COLOR_W-1:0]               r_pixel_color, w_pixel_color_nxt;
  logic                             r_busy, w_busy_nxt;
  logic                             w_advance;
  logic [OFF_W-1:0]                 w_dx, w_dy;
  logic                             w_in_box;

  sprite_offset_calc u_offset (
    .i_h_pos    (r_h),
    .i_v_pos    (r_v),
    .i_anchor_x (attr_x),
    .i_anchor_y (attr_y),
    .o_dx_c     (w_dx),
    .o_dy_c     (w_dy),
    .o_in_box_c (w_in_box)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= IDLE;
      r_k           <= 2'd0;
      r_ids         <= '0;
      r_h           <= '0;
      r_v           <= '0;
      r_attr_id     <= '0;
      r_mem_rd_en   <= 1'b0;
      r_mem_addr    <= '0;
      r_pixel_valid <= 1'b0;
      r_pixel_hit   <= 1'b0;
      r_pixel_color <= BG_COLOR;
      r_busy        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_k           <= w_k_nxt;
      r_ids         <= w_ids_nxt;
      r_h           <= w_h_nxt;
      r_v           <= w_v_nxt;
      r_attr_id     <= w_attr_id_nxt;
      r_mem_rd_en   <= w_mem_rd_en_nxt;
      r_mem_addr    <= w_mem_addr_nxt;
      r_pixel_valid <= w_pixel_valid_nxt;
      r_pixel_hit   <= w_pixel_hit_nxt;
      r_pixel_color <= w_pixel_color_nxt;
      r_busy        <= w_busy_nxt;
    end
  end

  // attr_id is loaded on entry to SCAN so the attribute read lands in MEM_REQ
  always_comb begin
    w_state_nxt       = r_state;
    w_k_nxt           = r_k;
    w_ids_nxt         = r_ids;
    w_h_nxt           = r_h;
    w_v_nxt           = r_v;
    w_attr_id_nxt     = r_attr_id;
    w_mem_rd_en_nxt   = 1'b0;
    w_mem_addr_nxt    = r_mem_addr;
    w_pixel_valid_nxt = 1'b0;
    w_pixel_hit_nxt   = r_pixel_hit;
    w_pixel_color_nxt = r_pixel_color;
    w_advance         = 1'b0;

    case (r_state)
      IDLE: begin
        if (candidates_valid) begin
          w_ids_nxt     = candidate_id;
          w_h_nxt       = H_pos_in;
          w_v_nxt       = V_pos_in;
          w_k_nxt       = 2'd0;
          w_attr_id_nxt = candidate_id[0];
          w_state_nxt   = SCAN;
        end
      end
      SCAN: begin
        if (r_ids[r_k] == NO_SPRITE_ID) w_advance = 1'b1;
        else                            w_state_nxt = MEM_REQ;
      end
      MEM_REQ: begin
        if (w_in_box) begin
          w_mem_rd_en_nxt = 1'b1;
          w_mem_addr_nxt  = {r_ids[r_k], w_dy, w_dx};
          w_state_nxt     = CHECK;
        end else begin
          w_advance = 1'b1;
        end
      end
      CHECK: begin
        if (mem_data != TRANSPARENT) begin
          w_pixel_color_nxt = mem_data;
          w_pixel_hit_nxt   = 1'b1;
          w_pixel_valid_nxt = 1'b1;
          w_state_nxt       = DONE;
        end else begin
          w_advance = 1'b1;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase

    // Move to the next slot, or finish with a miss after the last one
    if (w_advance) begin
      if (r_k == LAST_SLOT) begin
        w_pixel_color_nxt = BG_COLOR;
        w_pixel_hit_nxt   = 1'b0;
        w_pixel_valid_nxt = 1'b1;
        w_state_nxt       = DONE;
      end else begin
        w_k_nxt       = r_k + 2'd1;
        w_attr_id_nxt = r_ids[r_k + 2'd1];
        w_state_nxt   = SCAN;
      end
    end

    w_busy_nxt = (w_state_nxt != IDLE);
  end

  assign busy        = r_busy;
  assign attr_id     = r_attr_id;
  assign mem_rd_en   = r_mem_rd_en;
  assign mem_addr    = r_mem_addr;
  assign pixel_valid = r_pixel_valid;
  assign pixel_hit   = r_pixel_hit;
  assign pixel_color = r_pixel_color;
endmodule

// File: tb/tb_sprite_pixel_resolver.sv
// Directed vector bench for sprite_pixel_resolver with attribute-table and
// sprite-ROM models.
module tb_sprite_pixel_resolver;
  import sprite_pkg::*;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             candidates_valid = 1'b0;
  logic [3:0][5:0]  candidate_id = '1;
  logic [9:0]       H_pos_in = '0;
  logic [9:0]       V_pos_in = '0;
  logic             busy;
  logic [5:0]       attr_id;
  logic [9:0]       attr_x, attr_y;
  logic             mem_rd_en;
  logic [13:0]      mem_addr;
  logic [8:0]       mem_data;
  logic             pixel_valid;
  logic             pixel_hit;
  logic [8:0]       pixel_color;

  always #5 clk = ~clk;

  sprite_pixel_resolver dut (
    .clk              (clk),
    .rst              (rst),
    .candidates_valid (candidates_valid),
    .candidate_id     (candidate_id),
    .H_pos_in         (H_pos_in),
    .V_pos_in         (V_pos_in),
    .busy             (busy),
    .attr_id          (attr_id),
    .attr_x           (attr_x),
    .attr_y           (attr_y),
    .mem_rd_en        (mem_rd_en),
    .mem_addr         (mem_addr),
    .mem_data         (mem_data),
    .pixel_valid      (pixel_valid),
    .pixel_hit        (pixel_hit),
    .pixel_color      (pixel_color)
  );

  // Attribute table: one cycle of read latency
  logic [9:0] ax [0:63];
  logic [9:0] ay [0:63];
  always @(posedge clk) begin
    attr_x <= ax[attr_id];
    attr_y <= ay[attr_id];
  end

  // Sprite ROM: texel is presented while the read strobe is up; otherwise an opaque junk value
  logic [8:0] rom [0:16383];
  assign mem_data = mem_rd_en ? rom[mem_addr] : 9'h0F0;

  int          n_reads = 0;
  int          n_pv = 0;
  logic [13:0] last_addr = '0;
  always @(posedge clk) begin
    if (mem_rd_en) begin
      n_reads++;
      last_addr = mem_addr;
    end
    if (pixel_valid) n_pv++;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0][5:0] ids;
    logic [9:0]      h;
    logic [9:0]      v;
    int              lat;
    logic            hit;
    logic [8:0]      color;
    int              reads;
    logic [13:0]     addr;
  } vec_t;

  function automatic vec_t mk(input logic [5:0] s0, input logic [5:0] s1, input logic [5:0] s2,
                              input logic [5:0] s3, input logic [9:0] h, input logic [9:0] v,
                              input int lat, input logic hit, input logic [8:0] color,
                              input int reads, input logic [13:0] addr);
    vec_t r;
    r.ids = {s3, s2, s1, s0};
    r.h = h; r.v = v; r.lat = lat; r.hit = hit; r.color = color;
    r.reads = reads; r.addr = addr;
    return r;
  endfunction

  task automatic run_vec(input int idx, input vec_t t);
    int got;
    string tag;
    tag = $sformatf("v%0d", idx);
    @(negedge clk);
    candidate_id = t.ids; H_pos_in = t.h; V_pos_in = t.v;
    n_reads = 0; n_pv = 0;
    candidates_valid = 1'b1;
    got = -1;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      candidates_valid = 1'b0;
      if (pixel_valid) begin
        got = n;
        break;
      end
    end
    chk({tag, "_latency"}, got, t.lat);
    chk({tag, "_hit"}, pixel_hit, t.hit);
    chk({tag, "_color"}, pixel_color, t.color);
    chk({tag, "_busy_done"}, busy, 1);
    @(posedge clk); #1;
    chk({tag, "_pv_one_cycle"}, pixel_valid, 0);
    chk({tag, "_busy_fall"}, busy, 0);
    chk({tag, "_color_held"}, pixel_color, t.color);
    repeat (2) @(posedge clk);
    #1;
    chk({tag, "_pv_count"}, n_pv, 1);
    chk({tag, "_reads"}, n_reads, t.reads);
    if (t.reads > 0) chk({tag, "_addr"}, last_addr, t.addr);
  endtask

  vec_t vecs [11];

  initial begin
    for (int i = 0; i < 16384; i++) rom[i] = 9'h1FF;
    for (int i = 0; i < 64; i++) begin ax[i] = 10'd0; ay[i] = 10'd0; end
    ax[5]  = 10'd100; ay[5]  = 10'd50;  rom[14'h0523] = 9'h0A5;
    rom[14'h0423] = 9'h1C0;
    ax[7]  = 10'd200; ay[7]  = 10'd200;
    rom[14'h09AA] = 9'h03C;
    ax[10] = 10'd20;  ay[10] = 10'd20;  rom[14'h0AFF] = 9'h111;

    vecs[0]  = mk(6'd5,  6'h3F, 6'h3F, 6'h3F, 10'd103, 10'd52, 3,  1'b1, 9'h0A5, 1, 14'h0523);
    vecs[1]  = mk(6'h3F, 6'h3F, 6'h3F, 6'h3F, 10'd0,   10'd0,  4,  1'b0, 9'h000, 0, 14'h0000);
    vecs[2]  = mk(6'd1,  6'd2,  6'd3,  6'd4,  10'd3,   10'd2,  12, 1'b1, 9'h1C0, 4, 14'h0423);
    vecs[3]  = mk(6'd7,  6'd9,  6'h3F, 6'h3F, 10'd10,  10'd10, 5,  1'b1, 9'h03C, 1, 14'h09AA);
    vecs[4]  = mk(6'h3F, 6'h3F, 6'h3F, 6'd5,  10'd103, 10'd52, 6,  1'b1, 9'h0A5, 1, 14'h0523);
    vecs[5]  = mk(6'd5,  6'd5,  6'h3F, 6'h3F, 10'd103, 10'd52, 3,  1'b1, 9'h0A5, 1, 14'h0523);
    vecs[6]  = mk(6'd1,  6'd1,  6'd1,  6'd1,  10'd3,   10'd2,  12, 1'b0, 9'h000, 4, 14'h0123);
    vecs[7]  = mk(6'd10, 6'h3F, 6'h3F, 6'h3F, 10'd35,  10'd35, 3,  1'b1, 9'h111, 1, 14'h0AFF);
    vecs[8]  = mk(6'd10, 6'h3F, 6'h3F, 6'h3F, 10'd36,  10'd20, 5,  1'b0, 9'h000, 0, 14'h0000);
    vecs[9]  = mk(6'd10, 6'h3F, 6'h3F, 6'h3F, 10'd19,  10'd20, 5,  1'b0, 9'h000, 0, 14'h0000);
    vecs[10] = mk(6'd1,  6'd7,  6'h3F, 6'd4,  10'd3,   10'd2,  9,  1'b1, 9'h1C0, 2, 14'h0423);

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_attr_id", attr_id, 0);
    chk("rst_mem_rd_en", mem_rd_en, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_pixel_valid", pixel_valid, 0);
    chk("rst_pixel_hit", pixel_hit, 0);
    chk("rst_pixel_color", pixel_color, 9'h000);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 11; i++) run_vec(i, vecs[i]);

    // Strobe again while busy: only the first request is served
    @(negedge clk);
    candidate_id = {6'h3F, 6'h3F, 6'h3F, 6'd5}; H_pos_in = 10'd103; V_pos_in = 10'd52;
    n_pv = 0;
    candidates_valid = 1'b1;
    @(posedge clk); #1;
    candidate_id = '1; H_pos_in = 10'd0; V_pos_in = 10'd0;
    @(posedge clk); #1;
    chk("busy_retrigger_busy", busy, 1);
    @(posedge clk); #1;
    candidates_valid = 1'b0;
    @(posedge clk); #1;
    chk("busy_retrigger_pv", pixel_valid, 1);
    chk("busy_retrigger_color", pixel_color, 9'h0A5);
    chk("busy_retrigger_hit", pixel_hit, 1);
    repeat (15) @(posedge clk);
    #1;
    chk("busy_retrigger_pv_count", n_pv, 1);

    // Reset asserted while in CHECK
    @(negedge clk);
    candidate_id = {6'h3F, 6'h3F, 6'h3F, 6'd5}; H_pos_in = 10'd103; V_pos_in = 10'd52;
    n_pv = 0;
    candidates_valid = 1'b1;
    @(posedge clk); #1;
    candidates_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("abort_in_check_rd_en", mem_rd_en, 1);
    rst = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_attr_id", attr_id, 0);
    chk("abort_mem_rd_en", mem_rd_en, 0);
    chk("abort_mem_addr", mem_addr, 0);
    chk("abort_pixel_hit", pixel_hit, 0);
    chk("abort_pixel_color", pixel_color, 9'h000);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("abort_pv_count", n_pv, 0);
    chk("abort_idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
